key_event_decoder: RTL

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder_if.sv | 29 ++
 rtl/key_event_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/key_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder_if
// Description : Debounced-key input and decoded-event output bundle for the
//               key event decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_decoder_if;
  logic key_flag;      // one-cycle pulse per debounced edge
  logic key_state;     // 0 = pressed, 1 = released (valid with key_flag)
  logic short_press;
  logic double_click;
  logic long_press;
  logic hold_repeat;
  logic busy;

  // Producer of key edges / consumer of decoded events
  modport master (
    output key_flag, key_state,
    input  short_press, double_click, long_press, hold_repeat, busy
  );

  // Decoder side
  modport slave (
    input  key_flag, key_state,
    output short_press, double_click, long_press, hold_repeat, busy
  );
endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies debounced key activity into short press, double
//               click, long press and auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned DBL_CNT    = 15_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  key_event_decoder_if.slave  kif
);

  // Terminal counts: the counter reaches these on the last cycle of a window
  localparam logic [31:0] C_LONG_TERM   = 32'(LONG_CNT - 1);
  localparam logic [31:0] C_DBL_TERM    = 32'(DBL_CNT - 1);
  localparam logic [31:0] C_REPEAT_TERM = 32'(REPEAT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        short_q, short_d;
  logic        double_q, double_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        busy_q, busy_d;

  logic        w_press_ev;
  logic        w_release_ev;

  // key_state only carries meaning alongside key_flag
  assign w_press_ev   = kif.key_flag & ~kif.key_state;
  assign w_release_ev = kif.key_flag &  kif.key_state;

  // Next-state, counter and pulse decode; every state change clears the counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (w_press_ev) begin
          state_d = S_PRESS1;
        end
      end
      S_PRESS1: begin
        // Release takes priority over the long-press timeout
        if (w_release_ev) begin
          state_d = S_WAIT2;
          cnt_d   = 32'd0;
        end else if (cnt_q == C_LONG_TERM) begin
          state_d = S_LONG;
          cnt_d   = 32'd0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT2: begin
        // Second press takes priority over the short-press timeout
        if (w_press_ev) begin
          state_d = S_PRESS2;
          cnt_d   = 32'd0;
        end else if (cnt_q == C_DBL_TERM) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PRESS2: begin
        // No timeout here: the double click completes only on release
        cnt_d = 32'd0;
        if (w_release_ev) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end
      end
      S_LONG: begin
        if (w_release_ev) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == C_REPEAT_TERM) begin
          cnt_d    = 32'd0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and registered outputs; reset aborts any sequence silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign kif.short_press  = short_q;
  assign kif.double_click = double_q;
  assign kif.long_press   = long_q;
  assign kif.hold_repeat  = repeat_q;
  assign kif.busy         = busy_q;

endmodule
`default_nettype wire
